// File: rtl/channel_hv_feeder_pkg.sv
// channel_hv_feeder_pkg: shared state type, default geometry and per-bit hypervector helpers
package channel_hv_feeder_pkg;
  localparam int HV_DIMENSION_DEF = 2000;
  localparam int MAX_NUM_CHANNEL_WIDTH_DEF = 7;
  localparam int FEATURE_WIDTH_DEF = 4;
  localparam int LEVELS = 2 ** FEATURE_WIDTH_DEF;
  localparam int STEP = HV_DIMENSION_DEF >> FEATURE_WIDTH_DEF;
  typedef enum logic {IDLE, STREAM} state_t;
  // Width-agnostic cell updates so any hypervector width can build them in a generate loop.
  function automatic logic rule90(logic left, logic right);
    return left ^ right;
  endfunction
  function automatic logic level_hv(logic seed, int idx, int lvl, int step);
    return seed ^ (idx < lvl * step);
  endfunction
endpackage

// File: rtl/channel_hv_feeder_rule90_step.sv
// rule90_step: one combinational generation of a cyclic Rule-90 cellular automaton
// Ports: x current generation, y next generation (both WIDTH bits, WIDTH >= 3)
module rule90_step
  import channel_hv_feeder_pkg::*;
#(
  parameter int WIDTH = HV_DIMENSION_DEF
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign y[i] = rule90(x[(i + WIDTH - 1) % WIDTH], x[(i + 1) % WIDTH]);
  end
endmodule

// File: rtl/channel_hv_feeder.sv
// channel_hv_feeder: streams one item-memory HV and one level HV per channel of a packed feature sample
// Ports: clk, rst (sync, active-high); sample_valid/sample_ready/features/num_channel take a sample;
// hv_valid/hv_ready/im/projm/hv_last/hv_channel present one registered beat per channel.
// Optional macro SAMPLE_PREFETCH_EN adds a one-deep pending-sample slot for back-to-back samples.
module channel_hv_feeder
  import channel_hv_feeder_pkg::*;
#(
  parameter int HV_DIMENSION = HV_DIMENSION_DEF,
  parameter int MAX_NUM_CHANNEL_WIDTH = MAX_NUM_CHANNEL_WIDTH_DEF,
  parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
  parameter logic [HV_DIMENSION-1:0] IM_SEED = HV_DIMENSION'(1),
  parameter logic [HV_DIMENSION-1:0] PROJ_SEED = '0
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                sample_valid,
  output logic                                                sample_ready,
  input  logic [(2**MAX_NUM_CHANNEL_WIDTH)*FEATURE_WIDTH-1:0] features,
  input  logic [MAX_NUM_CHANNEL_WIDTH-1:0]                    num_channel,
  output logic                                                hv_valid,
  input  logic                                                hv_ready,
  output logic [HV_DIMENSION-1:0]                             im,
  output logic [HV_DIMENSION-1:0]                             projm,
  output logic                                                hv_last,
  output logic [MAX_NUM_CHANNEL_WIDTH-1:0]                    hv_channel
);
  localparam int FW = FEATURE_WIDTH;
  localparam int CW = MAX_NUM_CHANNEL_WIDTH;
  localparam int SW = (2 ** CW) * FW;
  localparam int STEP_L = HV_DIMENSION >> FW;
  state_t state, state_n;
  logic [SW-1:0] feat_q, src_feat;
  logic [CW-1:0] num_q, src_num, nxt_ch;
  logic [FW-1:0] lvl;
  logic [HV_DIMENSION-1:0] lvl_hv, im_step;
  logic sample_fire, hv_fire, adv, done, take, load;
`ifdef SAMPLE_PREFETCH_EN
  logic pend_full, park;
  logic [SW-1:0] pend_feat;
  logic [CW-1:0] pend_num;
  assign sample_ready = !pend_full;
  // A new sample starts either from idle or right on the last-beat fire; the pending slot wins.
  assign take = (state == IDLE || done) && (pend_full || sample_fire);
  assign park = sample_fire && state == STREAM && !done;
  assign src_feat = pend_full ? pend_feat : features;
  assign src_num = pend_full ? pend_num : num_channel;
  always_ff @(posedge clk)
    if (rst) pend_full <= 1'b0;
    else if (park) pend_full <= 1'b1;
    else if (take) pend_full <= 1'b0;
  always_ff @(posedge clk)
    if (park) begin
      pend_feat <= features;
      pend_num <= num_channel;
    end
`else
  assign sample_ready = state == IDLE;
  assign take = sample_fire;
  assign src_feat = features;
  assign src_num = num_channel;
`endif
  assign sample_fire = sample_valid && sample_ready;
  assign hv_fire = hv_valid && hv_ready;
  assign done = hv_fire && hv_last;
  assign adv = hv_fire && !hv_last;
  assign load = take && src_num != '0;
  assign nxt_ch = hv_channel + 1'b1;
  assign lvl = load ? src_feat[FW-1:0] : feat_q[int'(nxt_ch) * FW +: FW];
  always_comb state_n = load ? STREAM : done ? IDLE : state;
  for (genvar i = 0; i < HV_DIMENSION; i++) begin : g_lvl
    assign lvl_hv[i] = level_hv(PROJ_SEED[i], i, int'(lvl), STEP_L);
  end
  rule90_step #(.WIDTH(HV_DIMENSION)) u_rule90 (.x(im), .y(im_step));
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      hv_valid <= 1'b0;
      hv_last <= 1'b0;
      hv_channel <= '0;
      im <= '0;
      projm <= '0;
      feat_q <= '0;
      num_q <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        feat_q <= src_feat;
        num_q <= src_num;
        im <= IM_SEED;
        projm <= lvl_hv;
        hv_channel <= '0;
        hv_last <= src_num == CW'(1);
        hv_valid <= 1'b1;
      end else if (adv) begin
        hv_channel <= nxt_ch;
        im <= im_step;
        projm <= lvl_hv;
        hv_last <= nxt_ch == num_q - CW'(1);
      end else if (done) hv_valid <= 1'b0;
    end
endmodule
